// File: rtl/dual_issue_fetch_buffer_if.sv
// Handshake bundle between fetch/issue and the dual-issue fetch buffer.
// The master side drives fetch and issue controls; the slave side is the buffer.
interface dual_issue_fetch_buffer_if #(
    parameter int els_p      = 4,
    parameter int pc_width_p = 22
);
    logic                                instr_v_i;
    logic [31:0]                         instr_i;
    logic [pc_width_p-1:0]               pc_i;
    logic                                ready_o;
    logic [0:1][31:0]                    instr_o;
    logic [0:1][pc_width_p-1:0]          pc_o;
    logic [1:0]                          v_o;
    logic [1:0]                          deq_i;
    logic                                flush_i;
    logic [$clog2(els_p+1)-1:0]          count_o;
    logic                                err_o;

    modport master (
        output instr_v_i, instr_i, pc_i, deq_i, flush_i,
        input  ready_o, instr_o, pc_o, v_o, count_o, err_o
    );

    modport slave (
        input  instr_v_i, instr_i, pc_i, deq_i, flush_i,
        output ready_o, instr_o, pc_o, v_o, count_o, err_o
    );
endinterface

// File: rtl/dual_issue_fetch_buffer.sv
// In-order instruction queue presenting the two oldest entries as an issue pair.
// Issue reports 0/1/2 consumed per cycle; flush discards everything.
module dual_issue_fetch_buffer #(
    parameter int els_p      = 4,
    parameter int pc_width_p = 22
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    dual_issue_fetch_buffer_if.slave  io
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    logic [31:0]           instr_mem [els_p];
    logic [pc_width_p-1:0] pc_mem    [els_p];

    logic [ptr_w-1:0] rptr_reg, wptr_reg;
    logic [cnt_w-1:0] count_reg;
    logic             err_reg;

    logic             ready;
    logic             enq;
    logic [1:0]       deq_req;
    logic [cnt_w-1:0] deq_eff;
    logic             deq_illegal;
    logic [ptr_w-1:0] rptr_next, wptr_next;
    logic [cnt_w-1:0] count_next;

    assign ready = (count_reg != cnt_w'(els_p));
    assign enq   = io.instr_v_i & ready & ~io.flush_i;

    // A request of 3 is treated as 2, then clamped to what is actually held.
    always_comb begin
        deq_req     = (io.deq_i == 2'd3) ? 2'd2 : io.deq_i;
        deq_illegal = (io.deq_i == 2'd3) || (cnt_w'(io.deq_i) > count_reg);
        deq_eff     = (cnt_w'(deq_req) > count_reg) ? count_reg : cnt_w'(deq_req);
        rptr_next   = rptr_reg + ptr_w'(deq_eff);
        wptr_next   = wptr_reg + ptr_w'(enq);
        count_next  = count_reg + cnt_w'(enq) - deq_eff;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else if (io.flush_i) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
            if (deq_illegal)
                err_reg <= 1'b1;
        end
    end

    // Storage is cleared on reset so invalid slots never show X.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                instr_mem[gi] <= '0;
                pc_mem[gi]    <= '0;
            end else if (enq && (wptr_reg == ptr_w'(gi))) begin
                instr_mem[gi] <= io.instr_i;
                pc_mem[gi]    <= io.pc_i;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [ptr_w-1:0] slot_ptr;
        assign slot_ptr      = rptr_reg + ptr_w'(gi);
        assign io.instr_o[gi] = instr_mem[slot_ptr];
        assign io.pc_o[gi]    = pc_mem[slot_ptr];
        assign io.v_o[gi]     = (count_reg > cnt_w'(gi));
    end

    assign io.ready_o = ready;
    assign io.count_o = count_reg;
    assign io.err_o   = err_reg;
endmodule

// File: tb/tb_dual_issue_fetch_buffer.sv
// Directed bench for the dual-issue fetch buffer with hand-computed expectations.
module tb_dual_issue_fetch_buffer;
    localparam int els_p      = 4;
    localparam int pc_width_p = 22;

    logic clk;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    dual_issue_fetch_buffer_if #(.els_p(els_p), .pc_width_p(pc_width_p)) ifc ();

    dual_issue_fetch_buffer #(.els_p(els_p), .pc_width_p(pc_width_p)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hDEAD_0000 | pc;
    endfunction

    // Apply one cycle of stimulus, then return inputs to idle and sample 1ns after the edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [1:0] deq, input logic flush);
        ifc.instr_v_i = v;
        ifc.pc_i      = pc[pc_width_p-1:0];
        ifc.instr_i   = instr_of(pc);
        ifc.deq_i     = deq;
        ifc.flush_i   = flush;
        @(posedge clk);
        #1;
        ifc.instr_v_i = 1'b0;
        ifc.deq_i     = 2'd0;
        ifc.flush_i   = 1'b0;
    endtask

    task automatic check_pair(input string tag, input logic [31:0] pc0, input logic [31:0] pc1);
        check({tag, ".pc0"},    32'(ifc.pc_o[0]), pc0);
        check({tag, ".pc1"},    32'(ifc.pc_o[1]), pc1);
        check({tag, ".instr0"}, ifc.instr_o[0],   instr_of(pc0));
        check({tag, ".instr1"}, ifc.instr_o[1],   instr_of(pc1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".count"},  32'(ifc.count_o), 32'd0);
        check({tag, ".v"},      32'(ifc.v_o),     32'd0);
        check({tag, ".ready"},  32'(ifc.ready_o), 32'd1);
        check({tag, ".err"},    32'(ifc.err_o),   32'd0);
        check({tag, ".pc0"},    32'(ifc.pc_o[0]), 32'd0);
        check({tag, ".instr0"}, ifc.instr_o[0],   32'd0);
        check({tag, ".instr1"}, ifc.instr_o[1],   32'd0);
    endtask

    initial begin
        ifc.instr_v_i = 1'b0;
        ifc.instr_i   = '0;
        ifc.pc_i      = '0;
        ifc.deq_i     = 2'd0;
        ifc.flush_i   = 1'b0;
        reset_n       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_reset_state("reset");

        // Fill to full with back-to-back enqueues.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 2'd0, 1'b0);
            check($sformatf("fill%0d.count", i), 32'(ifc.count_o), 32'(i + 1));
        end
        check("full.ready", 32'(ifc.ready_o), 32'd0);
        check("full.v",     32'(ifc.v_o),     32'd3);
        check_pair("full", 32'h100, 32'h101);

        // Dual dequeue while full: the same-cycle enqueue must be refused.
        cycle(1'b1, 32'h1FF, 2'd2, 1'b0);
        check("deq2.count", 32'(ifc.count_o), 32'd2);
        check_pair("deq2", 32'h102, 32'h103);
        cycle(1'b1, 32'h104, 2'd0, 1'b0);
        check("enq104.count", 32'(ifc.count_o), 32'd3);
        cycle(1'b1, 32'h105, 2'd0, 1'b0);
        check("enq105.count", 32'(ifc.count_o), 32'd4);
        cycle(1'b0, 32'h0, 2'd2, 1'b0);
        check("wrap.count", 32'(ifc.count_o), 32'd2);
        check("wrap.v",     32'(ifc.v_o),     32'd3);
        check_pair("wrap", 32'h104, 32'h105);

        // Single issue with concurrent enqueue, starting from a clean count of 1.
        cycle(1'b0, 32'h0, 2'd0, 1'b1);
        check("flush1.count", 32'(ifc.count_o), 32'd0);
        cycle(1'b1, 32'h200, 2'd0, 1'b0);
        check("one.pc0", 32'(ifc.pc_o[0]), 32'h200);
        check("one.v",   32'(ifc.v_o),     32'd1);
        cycle(1'b1, 32'h201, 2'd1, 1'b0);
        check("single.count", 32'(ifc.count_o), 32'd1);
        check("single.pc0",   32'(ifc.pc_o[0]), 32'h201);
        check("single.v",     32'(ifc.v_o),     32'd1);

        // Steady one-in/one-out stream never stalls.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream%0d.ready", i), 32'(ifc.ready_o), 32'd1);
            cycle(1'b1, 32'h300 + 32'(i), 2'd1, 1'b0);
            check($sformatf("stream%0d.pc0", i),   32'(ifc.pc_o[0]), 32'h300 + 32'(i));
            check($sformatf("stream%0d.count", i), 32'(ifc.count_o), 32'd1);
        end

        // Flush beats a same-cycle enqueue and dequeue.
        cycle(1'b1, 32'h310, 2'd0, 1'b0);
        cycle(1'b1, 32'h311, 2'd0, 1'b0);
        check("pre_flush.count", 32'(ifc.count_o), 32'd3);
        cycle(1'b1, 32'h3FF, 2'd1, 1'b1);
        check("flush.count", 32'(ifc.count_o), 32'd0);
        check("flush.v",     32'(ifc.v_o),     32'd0);
        check("flush.ready", 32'(ifc.ready_o), 32'd1);
        check("flush.err",   32'(ifc.err_o),   32'd0);
        cycle(1'b1, 32'h400, 2'd0, 1'b0);
        check("post_flush.count", 32'(ifc.count_o), 32'd1);
        check("post_flush.pc0",   32'(ifc.pc_o[0]), 32'h400);

        // Illegal dequeues: over-request, then 3 while empty.
        cycle(1'b0, 32'h0, 2'd2, 1'b0);
        check("illegal2.count", 32'(ifc.count_o), 32'd0);
        check("illegal2.err",   32'(ifc.err_o),   32'd1);
        cycle(1'b0, 32'h0, 2'd3, 1'b0);
        check("illegal3.count", 32'(ifc.count_o), 32'd0);
        check("illegal3.err",   32'(ifc.err_o),   32'd1);
        cycle(1'b1, 32'h500, 2'd0, 1'b0);
        check("sticky.err",   32'(ifc.err_o),   32'd1);
        check("sticky.count", 32'(ifc.count_o), 32'd1);

        // Mid-operation reset while enqueuing.
        cycle(1'b1, 32'h501, 2'd0, 1'b0);
        cycle(1'b1, 32'h502, 2'd0, 1'b0);
        check("pre_rst.count", 32'(ifc.count_o), 32'd3);
        reset_n = 1'b0;
        cycle(1'b1, 32'h503, 2'd1, 1'b0);
        reset_n = 1'b1;
        check_reset_state("mid_rst");

        // Dual dequeue from rptr=3 wraps to rptr=1.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h600 + 32'(i), 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 2'd1, 1'b0);
        cycle(1'b1, 32'h604, 2'd0, 1'b0);
        cycle(1'b1, 32'h605, 2'd0, 1'b0);
        check_pair("rptr3", 32'h603, 32'h604);
        cycle(1'b0, 32'h0, 2'd2, 1'b0);
        check("rptr_wrap.count", 32'(ifc.count_o), 32'd1);
        check("rptr_wrap.pc0",   32'(ifc.pc_o[0]), 32'h605);
        check("rptr_wrap.v",     32'(ifc.v_o),     32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
